count_capture: RTL

Timestamp capture stage downstream of the 16-bit free-running counter. It consumes the counter's `count` and `tc` outputs and extends them with a wrap (epoch) counter to form a 32-bit timestamp. On each synchronized rising edge of an external asynchronous event, it snapshots the timestamp into a small show-ahead FIFO. A valid/ready port drains the FIFO to the reader, and a sticky flag reports dropped captures.

---
 rtl/count_capture_pkg.sv | 10 +
 rtl/ts_fifo.sv | 57 +++++
 rtl/count_capture.sv | 80 ++++++++
 3 files changed

// File: rtl/count_capture_pkg.sv
// Shared widths and the timestamp type for the count_capture stage.
package count_capture_pkg;

  localparam int CNT_W   = 16;
  localparam int EPOCH_W = 16;
  localparam int TS_W    = EPOCH_W + CNT_W;

  typedef logic [TS_W-1:0] ts_t;

endpackage

// File: rtl/ts_fifo.sv
// Show-ahead synchronous FIFO. Overfull pushes are refused unless a pop frees a slot
// in the same cycle; the output holds the last popped word while empty.
module ts_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic [W-1:0]  last_q;
  logic          do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign dout_o  = empty_o ? last_q : mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/count_capture.sv
// Timestamp capture: epoch-extended counter snapshotted on synchronized rising edges
// of cap_in into a show-ahead FIFO, with a sticky flag for dropped captures.
module count_capture #(
  parameter int CNT_W       = count_capture_pkg::CNT_W,
  parameter int EPOCH_W     = count_capture_pkg::EPOCH_W,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  localparam int TS_W       = EPOCH_W + CNT_W,
  localparam int LW         = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  count,
  input  logic              tc,
  input  logic              cap_in,
  input  logic              cap_ena,
  input  logic              clr_ovf,
  output logic [TS_W-1:0]   ts_data,
  output logic              ts_valid,
  input  logic              ts_ready,
  output logic [LW-1:0]     level,
  output logic              overflow
);

  localparam int WW = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [WW-1:0]          warm_q;
  logic                   tc_q;
  logic [EPOCH_W-1:0]     epoch_q;
  logic                   ovf_q;

  logic sync_last, armed, cap_evt, fifo_full, fifo_empty, drop;

  assign sync_last = sync_q[SYNC_STAGES-1];
  // Edges are masked until the edge register holds a real cap_in sample, so a level
  // already high at reset release is not mistaken for a rising edge.
  assign armed     = (warm_q == WW'(SYNC_STAGES + 1));
  assign cap_evt   = sync_last & ~prev_q & cap_ena & armed;
  assign drop      = cap_evt & fifo_full & ~ts_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      warm_q  <= '0;
      tc_q    <= 1'b0;
      epoch_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cap_in};
      prev_q <= sync_last;
      if (!armed) warm_q <= warm_q + WW'(1);
      tc_q <= tc;
      if (tc & ~tc_q) epoch_q <= epoch_q + EPOCH_W'(1);
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  ts_fifo #(
    .DEPTH (DEPTH),
    .W     (TS_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (cap_evt),
    .din_i   ({epoch_q, count}),
    .pop_i   (ts_ready),
    .dout_o  (ts_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign ts_valid = ~fifo_empty;
  assign overflow = ovf_q;

endmodule
